// File: rtl/mux_nx1_stream.sv
// N-input streaming multiplexer with a registered output stage; explicit-select or round-robin grant.
// Optional output handshake counter (beat_cnt) is enabled by defining MUX_NX1_BEAT_CNT_EN.
module mux_nx1_stream #(
    parameter int N_CH   = 8,
    parameter int DATA_W = 8,
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef MUX_NX1_BEAT_CNT_EN
    output logic [15:0]              beat_cnt,
`endif
    output logic [SEL_W-1:0]         out_ch
);

    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] g);
        return (g == SEL_W'(N_CH - 1)) ? '0 : g + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [DATA_W-1:0]    r_data_p1;
    logic                 r_vld_p1;
    logic [SEL_W-1:0]     r_ch_p1;
    logic [SEL_W-1:0]     r_rr_ptr;

    logic                 w_load_en;
    logic                 w_grant_vld;
    logic [SEL_W-1:0]     w_grant;
    logic [DATA_W-1:0]    w_data_p0;
    logic                 w_xfer_p0;
    logic [2*N_CH-1:0]    w_rot;
    logic [SEL_W:0]       w_rr_sum;
    int                   w_off;

    assign w_load_en = !r_vld_p1 || out_ready;

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_off       = 0;
        w_rot       = {in_valid, in_valid} >> r_rr_ptr;
        w_rr_sum    = '0;
        if (!mode) begin
            // Out-of-range sel matches no k, so it simply never grants.
            for (int k = 0; k < N_CH; k++) begin
                if (sel == SEL_W'(k) && in_valid[k]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = sel;
                end
            end
        end else begin
            // Rotated copy puts rr_ptr at bit 0; lowest set bit is the next channel in ring order.
            for (int j = N_CH - 1; j >= 0; j--) begin
                if (w_rot[j]) begin
                    w_grant_vld = 1'b1;
                    w_off       = j;
                end
            end
            w_rr_sum = {1'b0, r_rr_ptr} + (SEL_W+1)'(w_off);
            if (w_rr_sum >= (SEL_W+1)'(N_CH))
                w_rr_sum = w_rr_sum - (SEL_W+1)'(N_CH);
            w_grant = w_rr_sum[SEL_W-1:0];
        end
    end

    always_comb begin
        w_data_p0 = '0;
        in_ready  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_grant == SEL_W'(k)) begin
                w_data_p0   = in_data[k*DATA_W +: DATA_W];
                in_ready[k] = !rst && w_load_en && w_grant_vld;
            end
        end
    end

    assign w_xfer_p0 = w_load_en && w_grant_vld;

    // ---- stage p0 -> p1: output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_ch_p1   <= '0;
            r_rr_ptr  <= '0;
        end else if (w_load_en) begin
            r_vld_p1 <= w_xfer_p0;
            if (w_xfer_p0) begin
                r_data_p1 <= w_data_p0;
                r_ch_p1   <= w_grant;
                if (mode)
                    r_rr_ptr <= rr_next(w_grant);
            end
        end
    end

    assign out_data  = r_data_p1;
    assign out_valid = r_vld_p1;
    assign out_ch    = r_ch_p1;

`ifdef MUX_NX1_BEAT_CNT_EN
    logic [15:0] r_beat_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_beat_cnt <= '0;
        else if (r_vld_p1 && out_ready)
            r_beat_cnt <= sat_inc16(r_beat_cnt);
    end

    assign beat_cnt = r_beat_cnt;
`endif

endmodule

// File: doc/mux_nx1_stream.md
Name: mux_nx1_stream

Overview:
Parametrised N-input, one-output streaming multiplexer with one registered output stage. Each channel has a valid/ready handshake. Two selection modes: explicit select and round-robin arbitration. It replaces the fixed 8:1 combinational mux where sources and sinks are flow-controlled. Placement is between multiple producers and a single shared consumer.

Parameters:
N_CH, 8, number of input channels (2..32)
DATA_W, 8, data width per channel in bits
SEL_W, $clog2(N_CH), width of select/channel-ID fields (derived, do not override)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
in_data  input  N_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
in_valid  input  N_CH  per-channel valid
in_ready  output  N_CH  per-channel ready (combinational)
mode  input  1  0 = explicit select via sel, 1 = round-robin
sel  input  SEL_W  channel index used when mode=0
out_data  output  DATA_W  registered output data
out_valid  output  1  registered output valid
out_ready  input  1  downstream ready
out_ch  output  SEL_W  index of the channel that supplied out_data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=0. While rst=1, in_ready is all 0.
- load_en = !out_valid | out_ready. The output register may accept a new beat this cycle.
- Grant, combinational:
  - mode=0: grant = sel when sel<N_CH and in_valid[sel]=1; otherwise no grant.
  - sel>=N_CH never grants and never hangs. Other valid channels are ignored.
  - mode=1: grant = first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ... N_CH-1, then 0 ... rr_ptr-1 (wrap-around). No valid input means no grant.
- in_ready[k] = load_en & grant_valid & (grant==k). At most one bit is high per cycle. in_ready never depends on in_valid of channel k alone.
- Transfer on channel g when in_valid[g] & in_ready[g]. Next edge: out_data=in_data[g], out_ch=g, out_valid=1.
- load_en=1 with no grant: out_valid clears to 0 on the next edge. out_data and out_ch hold their last value.
- out_valid=1 and out_ready=0: out_data, out_valid and out_ch are held stable. No input is accepted.
- Latency: 1 cycle from input transfer to out_valid. Full throughput is 1 beat/cycle while out_ready=1.
- rr_ptr updates only on a transfer while mode=1: rr_ptr = (g==N_CH-1) ? 0 : g+1. It is unchanged in mode=0.
- Changing mode or sel takes effect in the same cycle's grant. The beat already in the output register is unaffected.
- Simultaneous output drain and input accept (out_valid=1, out_ready=1, transfer) replaces the register contents in one edge with no bubble.
- Reset asserted mid-stream discards any held beat. After reset, arbitration restarts at channel 0.
- Fairness (mode=1): with all N_CH channels continuously valid and out_ready=1, each channel gets exactly one grant per N_CH cycles.

Optional Feature:
- Macro: MUX_NX1_BEAT_CNT_EN.
- Defined: adds output port beat_cnt (output, 16 bits).
  - Counts output handshakes (out_valid & out_ready).
  - Saturates at 16'hFFFF; does not wrap.
  - Cleared to 0 by rst.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then mode=0, sel=3, in_valid=8'h08, in_data ch3=8'hA5, out_ready=1 -> in_ready=8'h08. Next cycle: out_valid=1, out_data=8'hA5, out_ch=3.
- Backpressure: hold out_ready=0 for 5 cycles with ch3 valid -> out_data stays 8'hA5 and in_ready=0 throughout. out_ready=1 -> next beat loads the following cycle with no loss or duplication.
- Round-robin: mode=1, in_valid=8'hFF, out_ready=1 for 16 cycles -> out_ch sequence 0,1,...,7,0,...,7.
- Skip and wrap: mode=1, in_valid=8'b1000_0010 -> out_ch alternates 1,7,1,7. Drop ch7 valid -> out_ch stays 1. rr_ptr wraps to 0 after ch7.
- Invalid select: mode=0, sel=7 with N_CH=6, in_valid all 1 -> in_ready all 0. out_valid drops to 0 one cycle after the last beat drains.
- Reset mid-stream: out_valid=1, out_ready=0, assert rst 1 cycle -> out_valid=0, out_data=0, out_ch=0. With MUX_NX1_BEAT_CNT_EN defined, beat_cnt=0 after reset, and beat_cnt=16'hFFFF holds after 70000 handshakes.
